// File: rtl/lock_pkg.sv
// =============================================================================
// Module      : lock_pkg
// Description : Shared key codes, sequencer states and default timing for the
//               combination-lock controller.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package lock_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    // Defaults assume a 50 MHz clock.
    localparam int unsigned c_default_open_cycles    = 250_000_000;
    localparam int unsigned c_default_err_cycles     = 50_000_000;
    localparam int unsigned c_default_lockout_cycles = 1_500_000_000;
    localparam int unsigned c_default_timeout_cycles = 500_000_000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        PROG    = 3'd4,
        ERROR   = 3'd5,
        LOCKOUT = 3'd6
    } state_t;

    typedef struct packed {
        logic unlock;
        logic err;
        logic lockout;
        logic prog;
    } ind_t;

    function automatic ind_t ind_of(input state_t s);
        ind_t ind;
        ind         = '0;
        ind.unlock  = (s == OPEN) || (s == PROG);
        ind.err     = (s == ERROR);
        ind.lockout = (s == LOCKOUT);
        ind.prog    = (s == PROG);
        return ind;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lock_timer.sv
// =============================================================================
// Module      : lock_timer
// Description : Shared 31-bit state timer with clear and terminal-count flag.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module lock_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic [30:0] i_limit,
    output logic        o_tc
);

    logic [30:0] r_count;
    logic [30:0] w_count;

    // A clear reads as zero in its own cycle, so that cycle is count 0.
    assign w_count = i_clr ? 31'd0 : r_count;
    assign o_tc    = (w_count == (i_limit - 31'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 31'd0;
        end else begin
            r_count <= w_count + 31'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lock_ctrl.sv
// =============================================================================
// Module      : lock_ctrl
// Description : Combination-lock sequencer: digit entry, code check, unlock
//               hold, failed-attempt lockout and code reprogramming.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module lock_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned              CODE_LEN       = 4,
    parameter logic [CODE_LEN*4-1:0]    DEFAULT_CODE   = 16'h1234,
    parameter int unsigned              MAX_FAIL       = 3,
    parameter int unsigned              OPEN_CYCLES    = c_default_open_cycles,
    parameter int unsigned              ERR_CYCLES     = c_default_err_cycles,
    parameter int unsigned              LOCKOUT_CYCLES = c_default_lockout_cycles,
    parameter int unsigned              TIMEOUT_CYCLES = c_default_timeout_cycles
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_flag,
    input  logic [3:0] key_value,
    output logic       unlock,
    output logic       err,
    output logic       lockout,
    output logic       prog,
    output logic [2:0] digit_cnt,
    output logic       key_ack
);

    localparam int          c_bw     = CODE_LEN * 4;
    localparam int          c_fail_w = $clog2(MAX_FAIL + 1);
    localparam logic [2:0]  c_full   = 3'(CODE_LEN);

    state_t              r_state;
    ind_t                r_ind;
    logic                r_flag_d;
    logic [c_bw-1:0]     r_buf;
    logic [c_bw-1:0]     r_code;
    logic [c_fail_w-1:0] r_fail_cnt;
    logic                r_match;
    logic                r_tmr_clr;

    logic                w_digit;
    logic                w_star;
    logic                w_hash;
    logic                w_full;
    logic                w_tc;
    logic [30:0]         w_limit;
    logic [c_bw-1:0]     w_shift;
    logic [c_fail_w-1:0] w_fail_next;

    assign w_digit     = r_flag_d && (key_value <= 4'd9);
    assign w_star      = r_flag_d && (key_value == KEY_STAR);
    assign w_hash      = r_flag_d && (key_value == KEY_HASH);
    assign w_full      = (digit_cnt == c_full);
    assign w_shift     = (r_buf << 4) | c_bw'(key_value);
    assign w_fail_next = r_fail_cnt + 1'b1;

    assign unlock  = r_ind.unlock;
    assign err     = r_ind.err;
    assign lockout = r_ind.lockout;
    assign prog    = r_ind.prog;

    always_comb begin
        w_limit = 31'(TIMEOUT_CYCLES);
        case (r_state)
            OPEN:    w_limit = 31'(OPEN_CYCLES);
            ERROR:   w_limit = 31'(ERR_CYCLES);
            LOCKOUT: w_limit = 31'(LOCKOUT_CYCLES);
            default: w_limit = 31'(TIMEOUT_CYCLES);
        endcase
    end

    lock_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (r_tmr_clr),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    // Timer expiry is tested before any key so that a coinciding key is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ind      <= '0;
            r_flag_d   <= 1'b0;
            r_buf      <= '0;
            r_code     <= DEFAULT_CODE;
            r_fail_cnt <= '0;
            r_match    <= 1'b0;
            r_tmr_clr  <= 1'b0;
            digit_cnt  <= 3'd0;
            key_ack    <= 1'b0;
        end else begin
            r_flag_d  <= key_flag;
            key_ack   <= 1'b0;
            r_tmr_clr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_digit) begin
                        r_state   <= ENTRY;
                        r_ind     <= ind_of(ENTRY);
                        r_buf     <= c_bw'(key_value);
                        digit_cnt <= 3'd1;
                        key_ack   <= 1'b1;
                        r_tmr_clr <= 1'b1;
                    end
                end
                ENTRY: begin
                    if (w_tc) begin
                        r_state   <= IDLE;
                        r_ind     <= ind_of(IDLE);
                        r_buf     <= '0;
                        digit_cnt <= 3'd0;
                        r_tmr_clr <= 1'b1;
                    end else if (w_digit && !w_full) begin
                        r_buf     <= w_shift;
                        digit_cnt <= digit_cnt + 3'd1;
                        key_ack   <= 1'b1;
                        r_tmr_clr <= 1'b1;
                    end else if (w_star) begin
                        r_state   <= IDLE;
                        r_ind     <= ind_of(IDLE);
                        r_buf     <= '0;
                        digit_cnt <= 3'd0;
                        key_ack   <= 1'b1;
                        r_tmr_clr <= 1'b1;
                    end else if (w_hash) begin
                        // Match is resolved here so the buffer can clear on entry to CHECK.
                        r_match   <= w_full && (r_buf == r_code);
                        r_state   <= CHECK;
                        r_ind     <= ind_of(CHECK);
                        r_buf     <= '0;
                        digit_cnt <= 3'd0;
                        key_ack   <= 1'b1;
                        r_tmr_clr <= 1'b1;
                    end
                end
                CHECK: begin
                    r_tmr_clr <= 1'b1;
                    if (r_match) begin
                        r_state    <= OPEN;
                        r_ind      <= ind_of(OPEN);
                        r_fail_cnt <= '0;
                    end else if (w_fail_next == c_fail_w'(MAX_FAIL)) begin
                        r_state    <= LOCKOUT;
                        r_ind      <= ind_of(LOCKOUT);
                        r_fail_cnt <= w_fail_next;
                    end else begin
                        r_state    <= ERROR;
                        r_ind      <= ind_of(ERROR);
                        r_fail_cnt <= w_fail_next;
                    end
                end
                OPEN: begin
                    if (w_tc) begin
                        r_state   <= IDLE;
                        r_ind     <= ind_of(IDLE);
                        r_tmr_clr <= 1'b1;
                    end else if (w_hash) begin
                        r_state   <= IDLE;
                        r_ind     <= ind_of(IDLE);
                        key_ack   <= 1'b1;
                        r_tmr_clr <= 1'b1;
                    end else if (w_star) begin
                        r_state   <= PROG;
                        r_ind     <= ind_of(PROG);
                        r_buf     <= '0;
                        digit_cnt <= 3'd0;
                        key_ack   <= 1'b1;
                        r_tmr_clr <= 1'b1;
                    end
                end
                PROG: begin
                    if (w_tc) begin
                        r_state   <= IDLE;
                        r_ind     <= ind_of(IDLE);
                        r_buf     <= '0;
                        digit_cnt <= 3'd0;
                        r_tmr_clr <= 1'b1;
                    end else if (w_digit && !w_full) begin
                        r_buf     <= w_shift;
                        digit_cnt <= digit_cnt + 3'd1;
                        key_ack   <= 1'b1;
                        r_tmr_clr <= 1'b1;
                    end else if (w_star) begin
                        r_state   <= IDLE;
                        r_ind     <= ind_of(IDLE);
                        r_buf     <= '0;
                        digit_cnt <= 3'd0;
                        key_ack   <= 1'b1;
                        r_tmr_clr <= 1'b1;
                    end else if (w_hash) begin
                        if (w_full) begin
                            r_code  <= r_buf;
                            r_state <= IDLE;
                            r_ind   <= ind_of(IDLE);
                        end else begin
                            r_state <= ERROR;
                            r_ind   <= ind_of(ERROR);
                        end
                        r_buf     <= '0;
                        digit_cnt <= 3'd0;
                        key_ack   <= 1'b1;
                        r_tmr_clr <= 1'b1;
                    end
                end
                ERROR: begin
                    if (w_tc) begin
                        r_state   <= IDLE;
                        r_ind     <= ind_of(IDLE);
                        r_tmr_clr <= 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (w_tc) begin
                        r_state    <= IDLE;
                        r_ind      <= ind_of(IDLE);
                        r_fail_cnt <= '0;
                        r_tmr_clr  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_ind     <= ind_of(IDLE);
                    r_buf     <= '0;
                    digit_cnt <= 3'd0;
                    r_tmr_clr <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lock_ctrl.sv
// =============================================================================
// Module      : tb_lock_ctrl
// Description : Directed self-checking bench for lock_ctrl with short timings.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_lock_ctrl;
    import lock_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_flag;
    logic [3:0] key_value;
    logic       unlock;
    logic       err;
    logic       lockout;
    logic       prog;
    logic [2:0] digit_cnt;
    logic       key_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lock_ctrl #(
        .CODE_LEN       (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_FAIL       (3),
        .OPEN_CYCLES    (20),
        .ERR_CYCLES     (10),
        .LOCKOUT_CYCLES (40),
        .TIMEOUT_CYCLES (30)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_flag  (key_flag),
        .key_value (key_value),
        .unlock    (unlock),
        .err       (err),
        .lockout   (lockout),
        .prog      (prog),
        .digit_cnt (digit_cnt),
        .key_ack   (key_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return unlock;
            1:       return err;
            default: return lockout;
        endcase
    endfunction

    // Called on a negedge; flag for one cycle, value the next, ack checked after.
    task automatic press(input logic [3:0] k, input logic exp_ack, input string tag);
        key_flag = 1'b1;
        @(negedge clk);
        key_flag  = 1'b0;
        key_value = k;
        @(negedge clk);
        check_eq({tag, "_ack"}, key_ack, exp_ack);
    endtask

    // Four digits then '#'; returns on the first cycle after CHECK.
    task automatic enter_code(input logic [15:0] code, input string tag);
        for (int i = 3; i >= 0; i--) press(code[i*4 +: 4], 1'b1, tag);
        press(KEY_HASH, 1'b1, tag);
        check_eq({tag, "_in_check"}, {29'd0, unlock, err, lockout}, 32'd0);
        @(negedge clk);
    endtask

    task automatic expect_pulse(input int which, input int exp_len, input string tag);
        int n;
        n = 0;
        while (sig(which) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq(tag, n, exp_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        key_flag  = 1'b0;
        key_value = 4'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {unlock, err, lockout, prog, digit_cnt, key_ack}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct default code; stray keys in IDLE are ignored
        press(4'd13, 1'b0, "idle_unknown");
        press(KEY_HASH, 1'b0, "idle_hash");
        press(KEY_STAR, 1'b0, "idle_star");
        press(4'd1, 1'b1, "d1");
        check_eq("cnt_after_1", digit_cnt, 3'd1);
        press(4'd2, 1'b1, "d2");
        press(4'd3, 1'b1, "d3");
        press(4'd4, 1'b1, "d4");
        check_eq("cnt_after_4", digit_cnt, 3'd4);
        press(KEY_HASH, 1'b1, "hash");
        check_eq("unlock_in_check", unlock, 1'b0);
        check_eq("cnt_in_check", digit_cnt, 3'd0);
        @(negedge clk);
        expect_pulse(0, 20, "open_len");

        // Three wrong attempts -> two errors, then lockout
        enter_code(16'h1111, "wrong1");
        expect_pulse(1, 10, "err_len1");
        enter_code(16'h1111, "wrong2");
        expect_pulse(1, 10, "err_len2");
        enter_code(16'h1111, "wrong3");
        check_eq("lockout_on", lockout, 1'b1);
        check_eq("err_in_lockout", err, 1'b0);
        press(4'd1, 1'b0, "lk1");
        press(4'd2, 1'b0, "lk2");
        press(4'd3, 1'b0, "lk3");
        press(4'd4, 1'b0, "lk4");
        press(KEY_HASH, 1'b0, "lkh");
        check_eq("unlock_in_lockout", unlock, 1'b0);
        expect_pulse(2, 30, "lockout_rest");
        enter_code(16'h1111, "after_lock");
        check_eq("fail_cleared_no_lockout", lockout, 1'b0);
        expect_pulse(1, 10, "err_after_lock");
        enter_code(16'h1234, "good_after_lock");
        expect_pulse(0, 20, "open_after_lock");

        // '*' aborts entry, short code errors, extra digits ignored
        press(4'd1, 1'b1, "ab1");
        press(4'd2, 1'b1, "ab2");
        press(KEY_STAR, 1'b1, "ab_star");
        check_eq("cnt_after_star", digit_cnt, 3'd0);
        enter_code(16'h1234, "after_abort");
        expect_pulse(0, 20, "open_after_abort");
        press(4'd1, 1'b1, "sh1");
        press(4'd2, 1'b1, "sh2");
        press(4'd3, 1'b1, "sh3");
        press(KEY_HASH, 1'b1, "sh_hash");
        @(negedge clk);
        expect_pulse(1, 10, "err_short");
        press(4'd1, 1'b1, "ln1");
        press(4'd2, 1'b1, "ln2");
        press(4'd3, 1'b1, "ln3");
        press(4'd4, 1'b1, "ln4");
        press(4'd5, 1'b0, "ln5");
        check_eq("cnt_saturated", digit_cnt, 3'd4);
        press(KEY_HASH, 1'b1, "ln_hash");
        @(negedge clk);
        expect_pulse(0, 20, "open_long");

        // Entry inactivity timeout after the last accepted digit
        press(4'd1, 1'b1, "to1");
        press(4'd2, 1'b1, "to2");
        check_eq("cnt_before_to", digit_cnt, 3'd2);
        repeat (29) @(negedge clk);
        check_eq("cnt_last_entry_cycle", digit_cnt, 3'd2);
        @(negedge clk);
        check_eq("cnt_after_to", digit_cnt, 3'd0);
        press(4'd3, 1'b1, "to3");
        press(4'd4, 1'b1, "to4");
        press(KEY_HASH, 1'b1, "to_hash");
        @(negedge clk);
        expect_pulse(1, 10, "err_after_to");

        // Reprogram to 5678 while open
        enter_code(16'h1234, "pre_prog");
        check_eq("open_before_prog", unlock, 1'b1);
        press(KEY_STAR, 1'b1, "pg_star");
        check_eq("prog_on", prog, 1'b1);
        check_eq("unlock_in_prog", unlock, 1'b1);
        press(4'd5, 1'b1, "pg5");
        press(4'd6, 1'b1, "pg6");
        press(4'd7, 1'b1, "pg7");
        press(4'd8, 1'b1, "pg8");
        check_eq("cnt_in_prog", digit_cnt, 3'd4);
        press(KEY_HASH, 1'b1, "pg_hash");
        check_eq("prog_off", prog, 1'b0);
        check_eq("unlock_after_prog", unlock, 1'b0);
        enter_code(16'h1234, "old_code");
        expect_pulse(1, 10, "err_old_code");
        enter_code(16'h5678, "new_code");
        expect_pulse(0, 20, "open_new_code");

        // Asynchronous reset while open restores the default code
        enter_code(16'h5678, "pre_reset");
        repeat (5) @(negedge clk);
        check_eq("open_before_reset", unlock, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_outputs", {unlock, err, lockout, prog, digit_cnt, key_ack}, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enter_code(16'h1234, "default_after_reset");
        expect_pulse(0, 20, "open_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lock_ctrl.md
# lock_ctrl

Combination-lock sequencer between the 4x3 keypad scanner and the lock actuator/indicator outputs. Consumes the scanner's one-cycle key events, collects digits, compares against a stored code, drives the unlock relay, counts failed attempts with timed lockout, and supports changing the code while open. The code is volatile and reverts to the default on reset.

## Interface
- CODE_LEN, 4: digits per code, 1..7.
- DEFAULT_CODE, 16'h1234: reset code, one BCD nibble per digit, first digit in MS nibble; width CODE_LEN*4.
- MAX_FAIL, 3: consecutive failures that trigger lockout, ≥1.
- OPEN_CYCLES, 250_000_000: unlock hold time (5 s at 50 MHz).
- ERR_CYCLES, 50_000_000: error indication time (1 s).
- LOCKOUT_CYCLES, 1_500_000_000: lockout time (30 s).
- TIMEOUT_CYCLES, 500_000_000: inactivity abort during entry or programming (10 s).
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- key_flag  in  1  one-cycle pulse per debounced key press.
- key_value  in  4  key code, valid the cycle after key_flag: 0-9 digits, 10 '*', 11 '#'; 12-15/unknown ignored.
- unlock  out  1  relay drive; reset 0.
- err  out  1  wrong code or bad program; reset 0.
- lockout  out  1  lockout active; reset 0.
- prog  out  1  programming mode active; reset 0.
- digit_cnt  out  3  digits currently buffered, for display; reset 0.
- key_ack  out  1  one-cycle pulse per accepted key; reset 0.

## Operation
- key_flag registered once; key_value sampled when the delayed flag is 1 ("key event"). Non-digit/non-'*'/'#' codes produce no event and no key_ack.
- Entry buffer: CODE_LEN*4 bits, shifts left, new digit enters LS nibble; digit_cnt saturates at CODE_LEN, further digits ignored (no key_ack).
- States:
  - IDLE: digit → load as first digit, ENTRY. '*' / '#' ignored.
  - ENTRY: digit → shift in. '*' → clear buffer, IDLE. '#' → CHECK. Timeout → clear, IDLE.
  - CHECK (1 cycle): match iff digit_cnt==CODE_LEN and buffer==code. Match → OPEN, fail_cnt=0. Mismatch → fail_cnt+1; if that equals MAX_FAIL → LOCKOUT, else ERROR. Buffer cleared.
  - OPEN: unlock=1. '#' → IDLE (relock). '*' → PROG. Timer expiry → IDLE. Digits ignored.
  - PROG: unlock stays 1, prog=1. Digits shift in. '#' with digit_cnt==CODE_LEN → code ← buffer, IDLE. '#' short → ERROR (fail_cnt unchanged). '*' or timeout → IDLE, code unchanged.
  - ERROR: err=1 for ERR_CYCLES, all keys ignored, then IDLE.
  - LOCKOUT: lockout=1 for LOCKOUT_CYCLES, keys ignored, then fail_cnt=0, IDLE.
- Outputs are pure functions of registered state (registered, no glitches); digit_cnt cleared on every transition into IDLE, CHECK, OPEN, PROG.
- fail_cnt cleared only by successful check, lockout expiry, or reset.

## Timing
- Key event latency: key_flag at cycle t → key_ack and state update at cycle t+2.
- '#' at t → CHECK at t+2 → unlock/err/lockout asserted at t+3.
- Single shared timer cleared on every state entry and on every accepted key in ENTRY/PROG; state exits on the cycle after timer == N-1, giving exactly N cycles of unlock/err/lockout.
- Key event coinciding with timer expiry: expiry wins, key dropped.
- Reset mid-operation: all outputs 0 on assertion, code=DEFAULT_CODE, fail_cnt=0, IDLE.

## Structure
- Package lock_pkg: KEY_STAR=10, KEY_HASH=11, state enum (IDLE, ENTRY, CHECK, OPEN, PROG, ERROR, LOCKOUT), default timing constants.
- Sub-module lock_timer: 31-bit up-counter with clear and terminal-count compare against a selected limit.

## Test plan
(sim parameters: OPEN=20, ERR=10, LOCKOUT=40, TIMEOUT=30, CODE_LEN=4)
- Keys 1,2,3,4,# → unlock high exactly 20 cycles starting 3 cycles after '#' flag; fail_cnt 0.
- Wrong code 1,1,1,1,# three times → err 10 cycles twice, third → lockout 40 cycles; correct code entered during lockout → no key_ack, no unlock.
- Open, '*', 5,6,7,8,# → prog drops, code=5678; 1,2,3,4,# → err; 5,6,7,8,# → unlock.
- 1,2,'*',1,2,3,4,# → unlock; 1,2,3,# → err (short code); five digits 1,2,3,4,5,# → digit_cnt stays 4, unlock.
- 1,2 then 30 idle cycles → IDLE, digit_cnt 0; subsequent 3,4,# → err.
- rst_n low during OPEN after reprogramming → unlock 0 immediately; 1,2,3,4,# after release → unlock.
